// File: rtl/output_latch_pkg.sv
// rtl/output_latch_pkg.sv - shared timer package: control-word fields and RW read formats
// Imported by the counter blocks so they agree on the control-word layout.
package output_latch_pkg;

  typedef enum logic [1:0] {
    RW_LATCH   = 2'b00,
    RW_LSB     = 2'b01,
    RW_MSB     = 2'b10,
    RW_LSB_MSB = 2'b11
  } rw_mode_e;

  typedef struct packed {
    logic [1:0] sc;
    rw_mode_e   rw;
    logic [2:0] mode;
    logic       bcd;
  } control_word_t;

endpackage

// File: rtl/output_latch.sv
// rtl/output_latch.sv - counter output/status latch and byte read sequencer
// A read is served from pre-edge state; latch/status commands then see the post-read flags.
module output_latch
  import output_latch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] count_value,
  input  logic [7:0]  status_in,
  input  logic [1:0]  rw_mode,
  input  logic        mode_write,
  input  logic        latch_cmd,
  input  logic        status_cmd,
  input  logic        read,
  output logic [7:0]  databus_out,
  output logic        data_valid
);

  logic [15:0] r_ol;
  logic [7:0]  r_sl;
  logic        r_count_latched;
  logic        r_status_latched;
  logic        r_byte_ptr;
  logic [7:0]  r_databus;
  logic        r_data_valid;

  rw_mode_e    w_rw;
  logic [7:0]  w_byte;
  logic        w_cl_next;
  logic        w_sl_next;
  logic        w_ptr_next;

  assign w_rw = rw_mode_e'(rw_mode);

  always_comb begin
    w_byte     = r_ol[7:0];
    w_cl_next  = r_count_latched;
    w_sl_next  = r_status_latched;
    w_ptr_next = r_byte_ptr;
    if (read) begin
      if (r_status_latched) begin
        w_byte    = r_sl;
        w_sl_next = 1'b0;
      end else begin
        case (w_rw)
          RW_LSB: begin
            w_byte    = r_ol[7:0];
            w_cl_next = 1'b0;
          end
          RW_MSB: begin
            w_byte    = r_ol[15:8];
            w_cl_next = 1'b0;
          end
          default: begin
            // 00 is treated as LSB-then-MSB
            w_byte     = r_byte_ptr ? r_ol[15:8] : r_ol[7:0];
            w_ptr_next = ~r_byte_ptr;
            if (r_byte_ptr) w_cl_next = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ol             <= 16'h0000;
      r_sl             <= 8'h00;
      r_count_latched  <= 1'b0;
      r_status_latched <= 1'b0;
      r_byte_ptr       <= 1'b0;
      r_databus        <= 8'h00;
      r_data_valid     <= 1'b0;
    end else if (mode_write) begin
      r_ol             <= count_value;
      r_count_latched  <= 1'b0;
      r_status_latched <= 1'b0;
      r_byte_ptr       <= 1'b0;
      r_data_valid     <= 1'b0;
    end else begin
      r_data_valid <= read;
      if (read) r_databus <= w_byte;
      r_byte_ptr <= w_ptr_next;

      if (status_cmd && !w_sl_next) begin
        r_sl             <= status_in;
        r_status_latched <= 1'b1;
      end else begin
        r_status_latched <= w_sl_next;
      end

      if (!w_cl_next) begin
        r_ol            <= count_value;
        r_count_latched <= latch_cmd;
      end else begin
        r_count_latched <= 1'b1;
      end
    end
  end

  assign databus_out = r_databus;
  assign data_valid  = r_data_valid;

endmodule

// File: tb/tb_output_latch.sv
// tb/tb_output_latch.sv - directed self-checking bench for output_latch
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_output_latch;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] count_value;
  logic [7:0]  status_in;
  logic [1:0]  rw_mode;
  logic        mode_write;
  logic        latch_cmd;
  logic        status_cmd;
  logic        read;
  logic [7:0]  databus_out;
  logic        data_valid;

  int n_checks = 0;
  int n_pass   = 0;

  output_latch dut (
    .clk         (clk),
    .reset       (reset),
    .count_value (count_value),
    .status_in   (status_in),
    .rw_mode     (rw_mode),
    .mode_write  (mode_write),
    .latch_cmd   (latch_cmd),
    .status_cmd  (status_cmd),
    .read        (read),
    .databus_out (databus_out),
    .data_valid  (data_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mode_write = 1'b0;
    latch_cmd  = 1'b0;
    status_cmd = 1'b0;
    read       = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [7:0] exp);
    read = 1'b1;
    step();
    chk({tag, "_dv"}, {15'd0, data_valid}, 16'd1);
    chk(tag, {8'd0, databus_out}, {8'd0, exp});
  endtask

  initial begin
    reset = 1'b1; count_value = 16'h0; status_in = 8'h0; rw_mode = 2'b11;
    mode_write = 1'b0; latch_cmd = 1'b0; status_cmd = 1'b0; read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus", {8'd0, databus_out}, 16'h0000);
    chk("rst_dv", {15'd0, data_valid}, 16'd0);
    reset = 1'b0;

    // transparent LSB/MSB pair
    count_value = 16'h1234;
    step();
    do_read("t28_lsb", 8'h34);
    do_read("t28_msb", 8'h12);
    step();
    chk("t28_dv_low", {15'd0, data_valid}, 16'd0);
    chk("t28_hold", {8'd0, databus_out}, 16'h0012);

    // second latch while held is ignored
    count_value = 16'hABCD; latch_cmd = 1'b1;
    step();
    count_value = 16'h0001; latch_cmd = 1'b1;
    step();
    do_read("t29_lsb", 8'hCD);
    do_read("t29_msb", 8'hAB);
    do_read("t29_transp", 8'h01);
    do_read("t29_transp_msb", 8'h00);

    // status has priority over count
    status_in = 8'h36; count_value = 16'h00FF; status_cmd = 1'b1; latch_cmd = 1'b1;
    step();
    count_value = 16'h5555;
    do_read("t30_status", 8'h36);
    do_read("t30_lsb", 8'hFF);
    do_read("t30_msb", 8'h00);

    // mode_write resets byte pointer and overrides a same-cycle read
    count_value = 16'h5678;
    step();
    do_read("t31_lsb", 8'h78);
    mode_write = 1'b1;
    step();
    chk("t31_mw_dv", {15'd0, data_valid}, 16'd0);
    chk("t31_mw_hold", {8'd0, databus_out}, 16'h0078);
    do_read("t31_lsb_again", 8'h78);
    mode_write = 1'b1; read = 1'b1;
    step();
    chk("mw_read_dv", {15'd0, data_valid}, 16'd0);
    chk("mw_read_hold", {8'd0, databus_out}, 16'h0078);

    // MSB-only read releasing the latch allows a same-cycle re-latch
    rw_mode = 2'b10; count_value = 16'h9A00; latch_cmd = 1'b1;
    step();
    count_value = 16'h7700; latch_cmd = 1'b1;
    do_read("t32_msb", 8'h9A);
    count_value = 16'h1100;
    do_read("t32_relatch", 8'h77);

    // LSB-only mode
    rw_mode = 2'b01; count_value = 16'h4321; latch_cmd = 1'b1;
    step();
    count_value = 16'h0000;
    do_read("rw01_latched", 8'h21);
    step();
    do_read("rw01_transp", 8'h00);

    // rw 00 behaves as LSB then MSB
    rw_mode = 2'b00; count_value = 16'hBEEF;
    step();
    do_read("rw00_lsb", 8'hEF);
    do_read("rw00_msb", 8'hBE);

    // second status_cmd while held is ignored
    rw_mode = 2'b11; count_value = 16'h0102;
    status_in = 8'h11; status_cmd = 1'b1;
    step();
    status_in = 8'h22; status_cmd = 1'b1;
    step();
    do_read("st_first", 8'h11);
    do_read("st_then_lsb", 8'h02);
    do_read("st_then_msb", 8'h01);

    // reset mid-sequence
    count_value = 16'hCAFE;
    step();
    do_read("t33_lsb", 8'hFE);
    reset = 1'b1;
    step();
    chk("t33_rst_bus", {8'd0, databus_out}, 16'h0000);
    chk("t33_rst_dv", {15'd0, data_valid}, 16'd0);
    reset = 1'b0;
    step();
    do_read("t33_lsb_after", 8'hFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
